// File: rtl/run_controller.sv
// ============================================================================
// Module      : run_controller
// Description : Multi-program run sequencer with a writable (start, done) PC
//               table, req/ack handshake and per-run cycle counter.
//               Optional watchdog enabled by defining RUN_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_controller #(
    parameter int PC_BITS      = 10,
    parameter int NUM_PROGS    = 4,
    parameter int SEL_BITS     = $clog2(NUM_PROGS),
    parameter int CYCLE_BITS   = 16,
    parameter int DEFAULT_DONE = 575,
    parameter int WDOG_CYCLES  = 4000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req,
    input  logic [SEL_BITS-1:0]   prog_sel,
    input  logic                  cfg_we,
    input  logic [SEL_BITS-1:0]   cfg_idx,
    input  logic [PC_BITS-1:0]    cfg_start,
    input  logic [PC_BITS-1:0]    cfg_done,
    input  logic [PC_BITS-1:0]    pc,
    output logic                  core_start,
    output logic [PC_BITS-1:0]    start_pc,
    output logic                  busy,
    output logic                  ack,
    output logic                  error,
    output logic [CYCLE_BITS-1:0] cycle_count
);

    localparam logic [SEL_BITS:0] C_NUM_PROGS = (SEL_BITS+1)'(NUM_PROGS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_BITS-1:0]   sel_q, sel_d;
    logic                  armed_q, armed_d;
    logic [CYCLE_BITS-1:0] count_q, count_d;
    logic                  error_q, error_d;
    logic                  core_start_q, core_start_d;
    logic                  busy_q, busy_d;
    logic                  ack_q, ack_d;
    logic [PC_BITS-1:0]    start_q [NUM_PROGS];
    logic [PC_BITS-1:0]    start_d [NUM_PROGS];
    logic [PC_BITS-1:0]    done_q  [NUM_PROGS];
    logic [PC_BITS-1:0]    done_d  [NUM_PROGS];

    logic                  sel_valid, cfg_valid, prog_valid;
    logic [PC_BITS-1:0]    cur_start, cur_done;
    logic [CYCLE_BITS-1:0] count_inc;
    logic                  done_hit, wdog_hit;

    // An invalid latched select has no table entry; read zeros instead.
    assign sel_valid  = ({1'b0, sel_q}    < C_NUM_PROGS);
    assign cfg_valid  = ({1'b0, cfg_idx}  < C_NUM_PROGS);
    assign prog_valid = ({1'b0, prog_sel} < C_NUM_PROGS);
    assign cur_start  = sel_valid ? start_q[sel_q] : '0;
    assign cur_done   = sel_valid ? done_q[sel_q]  : '0;
    assign count_inc  = (count_q == '1) ? count_q : count_q + 1'b1;
    assign done_hit   = (pc == cur_done);

`ifdef RUN_WATCHDOG_EN
    assign wdog_hit = (count_inc == CYCLE_BITS'(WDOG_CYCLES));
`else
    logic unused_wdog;
    assign unused_wdog = ^CYCLE_BITS'(WDOG_CYCLES);
    assign wdog_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        armed_d = armed_q;
        count_d = count_q;
        error_d = error_q;
        start_d = start_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (cfg_we && cfg_valid) begin
                    start_d[cfg_idx] = cfg_start;
                    done_d[cfg_idx]  = cfg_done;
                end
                // A new run requires req to have been seen low while idle.
                if (!req) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    armed_d = 1'b0;
                    sel_d   = prog_sel;
                    if (prog_valid) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_DONE;
                        error_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                count_d = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                count_d = count_inc;
                if (!req) begin
                    state_d = S_IDLE;
                end else if (done_hit) begin
                    state_d = S_DONE;
                    error_d = 1'b0;
                end else if (wdog_hit) begin
                    state_d = S_DONE;
                    error_d = 1'b1;
                end
            end
            S_DONE: begin
                if (!req) begin
                    state_d = S_IDLE;
                    error_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        core_start_d = (state_d != S_RUN);
        busy_d       = (state_d == S_LOAD) || (state_d == S_RUN);
        ack_d        = (state_d == S_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sel_q        <= '0;
            armed_q      <= 1'b1;
            count_q      <= '0;
            error_q      <= 1'b0;
            core_start_q <= 1'b1;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            for (int i = 0; i < NUM_PROGS; i++) begin
                start_q[i] <= '0;
                done_q[i]  <= PC_BITS'(DEFAULT_DONE);
            end
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            armed_q      <= armed_d;
            count_q      <= count_d;
            error_q      <= error_d;
            core_start_q <= core_start_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            start_q      <= start_d;
            done_q       <= done_d;
        end
    end

    assign core_start  = core_start_q;
    assign start_pc    = cur_start;
    assign busy        = busy_q;
    assign ack         = ack_q;
    assign error       = error_q;
    assign cycle_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_run_controller.sv
// ============================================================================
// Module      : tb_run_controller
// Description : Directed self-checking bench for run_controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_run_controller;

    localparam int PC_BITS    = 10;
    localparam int NUM_PROGS  = 3;
    localparam int SEL_BITS   = 2;
    localparam int CYCLE_BITS = 16;
    localparam int WDOG       = 50;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic                  req;
    logic [SEL_BITS-1:0]   prog_sel;
    logic                  cfg_we;
    logic [SEL_BITS-1:0]   cfg_idx;
    logic [PC_BITS-1:0]    cfg_start;
    logic [PC_BITS-1:0]    cfg_done;
    logic [PC_BITS-1:0]    pc;
    logic                  core_start;
    logic [PC_BITS-1:0]    start_pc;
    logic                  busy;
    logic                  ack;
    logic                  error;
    logic [CYCLE_BITS-1:0] cycle_count;

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc;
    logic [PC_BITS-1:0] prev_pc;
    logic overlap_seen = 1'b0;

    run_controller #(
        .PC_BITS     (PC_BITS),
        .NUM_PROGS   (NUM_PROGS),
        .CYCLE_BITS  (CYCLE_BITS),
        .DEFAULT_DONE(575),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req        (req),
        .prog_sel   (prog_sel),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_start  (cfg_start),
        .cfg_done   (cfg_done),
        .pc         (pc),
        .core_start (core_start),
        .start_pc   (start_pc),
        .busy       (busy),
        .ack        (ack),
        .error      (error),
        .cycle_count(cycle_count)
    );

    always #5 clock = ~clock;

    // Program counter model: load start_pc while core_start, else step by one.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        pc <= '0;
        else if (core_start) pc <= start_pc;
        else                 pc <= pc + 1'b1;
    end

    always @(negedge clock) begin
        if (ack === 1'b1 && busy === 1'b1) overlap_seen = 1'b1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input int bound, output int cycles, output logic [PC_BITS-1:0] last_pc);
        cycles  = 0;
        last_pc = pc;
        while (ack !== 1'b1 && cycles < bound) begin
            last_pc = pc;
            tick();
            cycles++;
        end
    endtask

    initial begin
        reset_n = 1'b1; req = 1'b0; prog_sel = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_start = '0; cfg_done = '0;

        // Reset asserted asynchronously mid-cycle
        #3 reset_n = 1'b0;
        #1;
        chk("rst_core_start", core_start, 1);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_cycle_count", cycle_count, 0);
        chk("rst_start_pc", start_pc, 0);
        @(negedge clock) reset_n = 1'b1;
        tick();

        // Default run, program 0: pc 0..575
        req = 1'b1; prog_sel = 2'd0;
        tick();
        chk("t2_load_busy", busy, 1);
        chk("t2_load_core_start", core_start, 1);
        tick();
        chk("t2_run_core_start", core_start, 0);
        chk("t2_run_first_pc", pc, 0);
        wait_ack(700, cyc, prev_pc);
        chk("t2_ack", ack, 1);
        chk("t2_run_cycles", cyc, 576);
        chk("t2_last_pc", prev_pc, 575);
        chk("t2_cycle_count", cycle_count, 576);
        chk("t2_error", error, 0);
        chk("t2_busy_low", busy, 0);
        tick(); tick();
        chk("t2_ack_held", ack, 1);
        chk("t2_count_frozen", cycle_count, 576);
        req = 1'b0;
        tick();
        chk("t2_ack_fall", ack, 0);

        // req back high immediately: no retrigger without a low idle cycle
        req = 1'b1;
        tick();
        chk("retrigger_busy", busy, 0);
        chk("retrigger_ack", ack, 0);
        req = 1'b0;
        tick();

        // Table write and request in the same idle cycle
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_start = 10'd100; cfg_done = 10'd431;
        req = 1'b1; prog_sel = 2'd2;
        tick();
        cfg_we = 1'b0;
        chk("t3_load_start_pc", start_pc, 100);
        chk("t3_load_busy", busy, 1);
        tick();
        chk("t3_run_first_pc", pc, 100);
        // Writes while running must be ignored
        cfg_we = 1'b1; cfg_idx = 2'd2; cfg_start = 10'd200; cfg_done = 10'd300;
        tick(); tick();
        cfg_we = 1'b0;
        wait_ack(400, cyc, prev_pc);
        chk("t3_ack", ack, 1);
        chk("t3_last_pc", prev_pc, 431);
        chk("t3_cycle_count", cycle_count, 332);
        chk("t3_error", error, 0);
        req = 1'b0;
        tick(); tick();
        chk("t3_entry_unchanged", start_pc, 100);

        // Abort at RUN cycle 10
        req = 1'b1; prog_sel = 2'd1;
        tick(); tick();
        repeat (9) tick();
        req = 1'b0;
        tick();
        chk("t4_abort_busy", busy, 0);
        chk("t4_abort_ack", ack, 0);
        chk("t4_abort_count", cycle_count, 10);
        chk("t4_abort_core_start", core_start, 1);
        tick();
        chk("t4_abort_ack_later", ack, 0);
        chk("t4_abort_count_hold", cycle_count, 10);

        // Abort and done match in the same cycle: abort wins
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_start = 10'd20; cfg_done = 10'd22;
        tick();
        cfg_we = 1'b0;
        req = 1'b1; prog_sel = 2'd1;
        tick();
        chk("t4b_load_start_pc", start_pc, 20);
        tick(); tick(); tick();
        chk("t4b_match_pc", pc, 22);
        req = 1'b0;
        tick();
        chk("t4b_ack", ack, 0);
        chk("t4b_busy", busy, 0);
        chk("t4b_count", cycle_count, 3);
        tick();
        chk("t4b_ack_later", ack, 0);

        // Invalid select
        req = 1'b1; prog_sel = 2'd3;
        tick();
        chk("t5_ack", ack, 1);
        chk("t5_error", error, 1);
        chk("t5_busy", busy, 0);
        chk("t5_core_start", core_start, 1);
        req = 1'b0;
        tick();
        chk("t5_ack_fall", ack, 0);
        chk("t5_error_clear", error, 0);

        // Unreachable done address
        cfg_we = 1'b1; cfg_idx = 2'd0; cfg_start = 10'd600; cfg_done = 10'd10;
        tick();
        cfg_we = 1'b0;
        req = 1'b1; prog_sel = 2'd0;
        tick(); tick();
        chk("t6_first_pc", pc, 600);
`ifdef RUN_WATCHDOG_EN
        wait_ack(100, cyc, prev_pc);
        chk("t6_wdog_ack", ack, 1);
        chk("t6_wdog_error", error, 1);
        chk("t6_wdog_count", cycle_count, WDOG);
        chk("t6_wdog_cycles", cyc, WDOG);
`else
        repeat (100) tick();
        chk("t6_no_ack", ack, 0);
        chk("t6_still_busy", busy, 1);
        chk("t6_count", cycle_count, 100);
`endif

        // Asynchronous reset mid-cycle reinitialises state and table
        #2 reset_n = 1'b0;
        #1;
        chk("t7_rst_busy", busy, 0);
        chk("t7_rst_ack", ack, 0);
        chk("t7_rst_error", error, 0);
        chk("t7_rst_count", cycle_count, 0);
        chk("t7_rst_core_start", core_start, 1);
        chk("t7_rst_table", start_pc, 0);
        @(negedge clock) reset_n = 1'b1;
        tick();

        chk("ack_busy_overlap", overlap_seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
